// File: rtl/fsm_set_multi_pkg.sv
// Shared types for the set/display mode controller.
// State and gesture-event encodings plus the event priority encoder.
package set_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    DIS_H       = 3'd1,
    SET_TIME    = 3'd2,
    SET_ALARM   = 3'd3,
    SEE_ALARM   = 3'd4,
    SEE_ALARM_H = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_LONG,
    EV_TRIPLE,
    EV_DOUBLE,
    EV_SHORT,
    EV_FOUR
  } evt_e;

  localparam int FLD_SEC  = 0;
  localparam int FLD_MIN  = 1;
  localparam int FLD_HOUR = 2;

  // long > triple > double > short > four
  function automatic evt_e evt_encode(
    input logic l,
    input logic t,
    input logic d,
    input logic s,
    input logic f
  );
    evt_e e;
    e = EV_NONE;
    priority case (1'b1)
      l:       e = EV_LONG;
      t:       e = EV_TRIPLE;
      d:       e = EV_DOUBLE;
      s:       e = EV_SHORT;
      f:       e = EV_FOUR;
      default: e = EV_NONE;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/fsm_set_multi_if.sv
// Gesture inputs and mode/display outputs of the set controller.
// master = controller, slave = gesture decoder / counters / display mux.
interface fsm_set_multi_if #(
  parameter int NUM_FIELDS = 3,
  parameter int AW         = 2
);

  logic                  set_long;
  logic                  set_double;
  logic                  set_short;
  logic                  set_triple;
  logic                  set_four;
  logic                  tick_1hz;
  logic [NUM_FIELDS-1:0] set_time;
  logic [NUM_FIELDS-1:0] set_alarm;
  logic [AW-1:0]         alarm_sel;
  logic                  dis_toa;
  logic                  dis_moh;
  logic                  edit_active;
  logic                  timeout_pulse;

  modport master (
    input  set_long, set_double, set_short,
    input  set_triple, set_four, tick_1hz,
    output set_time, set_alarm, alarm_sel,
    output dis_toa, dis_moh, edit_active,
    output timeout_pulse
  );

  modport slave (
    output set_long, set_double, set_short,
    output set_triple, set_four, tick_1hz,
    input  set_time, set_alarm, alarm_sel,
    input  dis_toa, dis_moh, edit_active,
    input  timeout_pulse
  );

endinterface

// File: rtl/fsm_set_multi_timeout_cnt.sv
// Inactivity counter: counts ticks since the last clear,
// pulses expire on the TIMEOUT_TICKS-th uncleared tick.
module set_timeout_cnt #(
  parameter int TIMEOUT_TICKS = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic tick,
  output logic expire
);

  localparam int CW =
    (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_TICKS - 1);

  logic [CW-1:0] cnt;

  assign expire = tick && !clr && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr || expire) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fsm_set_multi.sv
// Set/display mode controller: gestures -> time/alarm edit and view
// modes, with per-field enables, alarm slot select and idle timeout.
module fsm_set_multi
  import set_pkg::*;
#(
  parameter int NUM_ALARMS    = 4,
  parameter int NUM_FIELDS    = 3,
  parameter int TIMEOUT_TICKS = 30,
  parameter int AW =
    (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input logic              clk,
  input logic              reset,
  fsm_set_multi_if.master  bus
);

  localparam int FW = $clog2(NUM_FIELDS);
  localparam logic [FW-1:0] FLD_LAST = FW'(NUM_FIELDS - 1);
  localparam logic [FW-1:0] FLD_0    = FW'(FLD_SEC);
  localparam logic [AW-1:0] SEL_LAST = AW'(NUM_ALARMS - 1);
  localparam logic [NUM_FIELDS-1:0] ONE = NUM_FIELDS'(1);

  state_e        state_q, state_d;
  logic [FW-1:0] fld_q, fld_d;
  logic [AW-1:0] sel_q, sel_d, sel_next;
  logic          tp_q;
  logic          any_ev;
  logic          clr;
  logic          expire;
  evt_e          ev;

  assign any_ev = bus.set_long | bus.set_double |
                  bus.set_short | bus.set_triple |
                  bus.set_four;
  assign clr = any_ev || (state_q == IDLE);
  assign ev  = evt_encode(bus.set_long, bus.set_triple,
                          bus.set_double, bus.set_short,
                          bus.set_four);
  assign sel_next = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;

  set_timeout_cnt #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .tick   (bus.tick_1hz),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    fld_d   = fld_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE, DIS_H: begin
        case (ev)
          EV_LONG: begin
            state_d = SET_TIME;
            fld_d   = FLD_0;
          end
          EV_DOUBLE: begin
            state_d = SET_ALARM;
            fld_d   = FLD_0;
          end
          EV_SHORT:
            state_d = (state_q == IDLE) ? DIS_H : IDLE;
          EV_FOUR: state_d = SEE_ALARM;
          default: ;
        endcase
      end
      SET_TIME, SET_ALARM: begin
        case (ev)
          EV_LONG: begin
            if (fld_q == FLD_LAST) begin
              state_d = IDLE;
              fld_d   = FLD_0;
            end else begin
              fld_d = fld_q + 1'b1;
            end
          end
          EV_TRIPLE: begin
            state_d = IDLE;
            fld_d   = FLD_0;
          end
          EV_SHORT:
            if (state_q == SET_ALARM) sel_d = sel_next;
          default: ;
        endcase
      end
      SEE_ALARM, SEE_ALARM_H: begin
        case (ev)
          EV_FOUR: state_d = IDLE;
          EV_SHORT:
            state_d = (state_q == SEE_ALARM) ?
                      SEE_ALARM_H : SEE_ALARM;
          EV_DOUBLE: sel_d = sel_next;
          default: ;
        endcase
      end
      default: begin
        state_d = IDLE;
        fld_d   = FLD_0;
      end
    endcase
    // expire already implies no event this cycle
    if (expire) begin
      state_d = IDLE;
      fld_d   = FLD_0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fld_q   <= FLD_0;
      sel_q   <= '0;
      tp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fld_q   <= fld_d;
      sel_q   <= sel_d;
      tp_q    <= expire;
    end
  end

  logic [NUM_FIELDS-1:0] st_o, sa_o;
  logic                  toa_o, moh_o, edit_o;

  always_comb begin
    st_o   = '0;
    sa_o   = '0;
    toa_o  = 1'b0;
    moh_o  = 1'b0;
    edit_o = 1'b0;
    case (state_q)
      DIS_H: moh_o = 1'b1;
      SET_TIME: begin
        st_o   = ONE << fld_q;
        moh_o  = (fld_q == FLD_LAST);
        edit_o = 1'b1;
      end
      SET_ALARM: begin
        sa_o   = ONE << fld_q;
        moh_o  = (fld_q == FLD_LAST);
        toa_o  = 1'b1;
        edit_o = 1'b1;
      end
      SEE_ALARM: toa_o = 1'b1;
      SEE_ALARM_H: begin
        toa_o = 1'b1;
        moh_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.set_time      = st_o;
  assign bus.set_alarm     = sa_o;
  assign bus.alarm_sel     = sel_q;
  assign bus.dis_toa       = toa_o;
  assign bus.dis_moh       = moh_o;
  assign bus.edit_active   = edit_o;
  assign bus.timeout_pulse = tp_q;

endmodule

// File: tb/tb_fsm_set_multi.sv
// Bench for fsm_set_multi: directed sequence with literal checks,
// then random gestures checked every cycle against a mode model.
module tb_fsm_set_multi;

  localparam int NA  = 4;
  localparam int NF  = 3;
  localparam int TMO = 30;
  localparam int AW  = 2;

  localparam int M_IDLE = 0;
  localparam int M_DISH = 1;
  localparam int M_TIME = 2;
  localparam int M_ALRM = 3;
  localparam int M_SEE  = 4;
  localparam int M_SEEH = 5;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  bit   chk_en;

  fsm_set_multi_if #(.NUM_FIELDS(NF), .AW(AW)) bus ();

  fsm_set_multi #(
    .NUM_ALARMS    (NA),
    .NUM_FIELDS    (NF),
    .TIMEOUT_TICKS (TMO),
    .AW            (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act,
                     input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Mode model: mode, field index, slot, idle ticks, pulse flag
  int m_st, m_fld, m_sel, m_idle;
  bit m_tp;

  always @(posedge clk) begin : model
    bit l, t, d, s, f, tk, anyp, tmo;
    l  = bus.set_long;
    t  = bus.set_triple;
    d  = bus.set_double;
    s  = bus.set_short;
    f  = bus.set_four;
    tk = bus.tick_1hz;
    if (reset) begin
      m_st = M_IDLE; m_fld = 0; m_sel = 0;
      m_idle = 0; m_tp = 0;
    end else begin
      anyp = l | t | d | s | f;
      tmo  = (m_st != M_IDLE) && !anyp && tk &&
             (m_idle == TMO - 1);
      if (anyp || m_st == M_IDLE || tmo) m_idle = 0;
      else if (tk) m_idle = m_idle + 1;
      m_tp = tmo;
      if (tmo) begin
        m_st = M_IDLE; m_fld = 0;
      end else if (m_st == M_IDLE || m_st == M_DISH) begin
        if (l) begin m_st = M_TIME; m_fld = 0; end
        else if (t) ;
        else if (d) begin m_st = M_ALRM; m_fld = 0; end
        else if (s) m_st = (m_st == M_IDLE) ? M_DISH : M_IDLE;
        else if (f) m_st = M_SEE;
      end else if (m_st == M_TIME || m_st == M_ALRM) begin
        if (l) begin
          if (m_fld == NF - 1) begin m_st = M_IDLE; m_fld = 0; end
          else m_fld = m_fld + 1;
        end else if (t) begin
          m_st = M_IDLE; m_fld = 0;
        end else if (d) ;
        else if (s && m_st == M_ALRM) m_sel = (m_sel + 1) % NA;
      end else begin
        if (l || t) ;
        else if (d) m_sel = (m_sel + 1) % NA;
        else if (s) m_st = (m_st == M_SEE) ? M_SEEH : M_SEE;
        else if (f) m_st = M_IDLE;
      end
    end
  end

  always @(negedge clk) begin : compare
    int e_st, e_sa, e_toa, e_moh, e_ed;
    if (chk_en) begin
      e_st  = (m_st == M_TIME) ? (1 << m_fld) : 0;
      e_sa  = (m_st == M_ALRM) ? (1 << m_fld) : 0;
      e_toa = (m_st == M_ALRM || m_st >= M_SEE) ? 1 : 0;
      e_ed  = (m_st == M_TIME || m_st == M_ALRM) ? 1 : 0;
      e_moh = (m_st == M_DISH || m_st == M_SEEH ||
               (e_ed == 1 && m_fld == NF - 1)) ? 1 : 0;
      chk("m_set_time", int'(bus.set_time), e_st);
      chk("m_set_alarm", int'(bus.set_alarm), e_sa);
      chk("m_alarm_sel", int'(bus.alarm_sel), m_sel);
      chk("m_dis_toa", int'(bus.dis_toa), e_toa);
      chk("m_dis_moh", int'(bus.dis_moh), e_moh);
      chk("m_edit", int'(bus.edit_active), e_ed);
      chk("m_tmo", int'(bus.timeout_pulse), int'(m_tp));
    end
  end

  task automatic cyc(input bit l, input bit t, input bit d,
                     input bit s, input bit f, input bit tk);
    bus.set_long   = l;
    bus.set_triple = t;
    bus.set_double = d;
    bus.set_short  = s;
    bus.set_four   = f;
    bus.tick_1hz   = tk;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 1);
  endtask

  int sel_exp[5] = '{1, 2, 3, 0, 1};
  int rates[4]   = '{2, 20, 60, 150};

  initial begin
    total  = 0;
    bad    = 0;
    chk_en = 0;
    reset  = 1'b1;
    bus.set_long = 0; bus.set_triple = 0; bus.set_double = 0;
    bus.set_short = 0; bus.set_four = 0; bus.tick_1hz = 0;
    @(negedge clk);
    chk_en = 1;
    idle(1);
    reset = 1'b0;
    chk("rst_set_time", int'(bus.set_time), 0);
    chk("rst_sel", int'(bus.alarm_sel), 0);
    chk("rst_tmo", int'(bus.timeout_pulse), 0);

    cyc(1, 0, 0, 0, 0, 0);
    chk("t_fld0", int'(bus.set_time), 1);
    idle(9);
    cyc(1, 0, 0, 0, 0, 0);
    chk("t_fld1", int'(bus.set_time), 2);
    idle(9);
    cyc(1, 0, 0, 0, 0, 0);
    chk("t_fld2", int'(bus.set_time), 4);
    chk("t_moh", int'(bus.dis_moh), 1);
    idle(9);
    cyc(1, 0, 0, 0, 0, 0);
    chk("t_exit", int'(bus.set_time), 0);
    chk("t_exit_ed", int'(bus.edit_active), 0);

    cyc(0, 0, 1, 0, 0, 0);
    chk("a_fld0", int'(bus.set_alarm), 1);
    chk("a_toa", int'(bus.dis_toa), 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 1, 0, 0);
      chk("a_sel", int'(bus.alarm_sel), sel_exp[i]);
    end
    cyc(0, 1, 0, 0, 0, 0);
    chk("a_abort", int'(bus.set_alarm), 0);
    chk("a_hold", int'(bus.alarm_sel), 1);

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("p_fld1", int'(bus.set_time), 2);
    cyc(1, 1, 0, 0, 0, 0);
    chk("p_long_wins", int'(bus.set_time), 4);
    chk("p_no_abort", int'(bus.edit_active), 1);
    cyc(0, 1, 0, 0, 0, 0);

    cyc(0, 0, 1, 0, 0, 0);
    ticks(29);
    chk("o_held1", int'(bus.set_alarm), 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("o_sel", int'(bus.alarm_sel), 2);
    ticks(29);
    chk("o_held2", int'(bus.set_alarm), 1);
    chk("o_no_pulse", int'(bus.timeout_pulse), 0);
    ticks(1);
    chk("o_abort", int'(bus.set_alarm), 0);
    chk("o_pulse", int'(bus.timeout_pulse), 1);
    idle(1);
    chk("o_pulse_1cyc", int'(bus.timeout_pulse), 0);

    cyc(0, 0, 0, 0, 1, 0);
    chk("v_toa", int'(bus.dis_toa), 1);
    chk("v_moh0", int'(bus.dis_moh), 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("v_moh1", int'(bus.dis_moh), 1);
    cyc(0, 0, 1, 0, 0, 0);
    chk("v_sel", int'(bus.alarm_sel), 3);
    cyc(0, 0, 0, 0, 1, 0);
    chk("v_exit", int'(bus.dis_toa), 0);

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("r_pre", int'(bus.set_time), 4);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("r_set_time", int'(bus.set_time), 0);
    chk("r_sel", int'(bus.alarm_sel), 0);
    chk("r_moh", int'(bus.dis_moh), 0);

    for (int seg = 0; seg < 8; seg++) begin
      int r;
      r = rates[seg % 4];
      for (int c = 0; c < 600; c++) begin
        reset = ($urandom_range(0, 999) == 0);
        cyc($urandom_range(0, 999) < r,
            $urandom_range(0, 999) < r,
            $urandom_range(0, 999) < r,
            $urandom_range(0, 999) < r,
            $urandom_range(0, 999) < r,
            $urandom_range(0, 1) == 1);
      end
    end
    reset = 1'b0;
    idle(2);
    chk_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsm_set_multi.md
Name: fsm_set_multi

Overview:
- Parametrised successor of the set/display mode controller for the Basys3 timer.
- Decodes debounced button-gesture pulses into time-edit, alarm-edit and alarm-view modes.
- Supports NUM_ALARMS alarm slots and NUM_FIELDS editable fields, plus an inactivity timeout that drops back to normal display.
- Sits between the gesture decoder and the time/alarm counter and display-mux blocks.

Parameters:
- NUM_ALARMS, 4: number of alarm slots; must be >=1.
- NUM_FIELDS, 3: editable fields per value, index 0 = seconds, top index = hours; must be >=2.
- TIMEOUT_TICKS, 30: tick_1hz pulses without a button event before a non-IDLE state aborts to IDLE; must be >=1.
- AW, $clog2(NUM_ALARMS) with minimum 1: width of alarm_sel.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous reset, active-high.
- set_long, in, 1: long-press pulse, one cycle.
- set_double, in, 1: double-press pulse.
- set_short, in, 1: short-press pulse.
- set_triple, in, 1: triple-press pulse.
- set_four, in, 1: quad-press pulse.
- tick_1hz, in, 1: one-cycle timebase pulse.
- set_time, out, NUM_FIELDS: one-hot field enable for the time counter; all zeros when not editing time.
- set_alarm, out, NUM_FIELDS: one-hot field enable for the selected alarm; all zeros when not editing an alarm.
- alarm_sel, out, AW: selected alarm slot.
- dis_toa, out, 1: display select, 0 = time, 1 = alarm.
- dis_moh, out, 1: display select, 0 = min:sec, 1 = hour view.
- edit_active, out, 1: high in SET_TIME or SET_ALARM.
- timeout_pulse, out, 1: one-cycle pulse on a timeout abort.

Behaviour:
- One clock; reset is synchronous and active-high, sampled on the clk rising edge.
- Reset values: state=IDLE, fld=0, alarm_sel=0, tmo_cnt=0, timeout_pulse=0; all other outputs decode to 0.
- Event priority when several pulses share a cycle: long > triple > double > short > four. Only the highest-priority event acts; the rest are dropped.
- State and counters are registered. Outputs are a Moore decode of state/fld/alarm_sel, except timeout_pulse, which is registered. An event in cycle n changes outputs in cycle n+1.
- IDLE transitions: long -> SET_TIME with fld=0; double -> SET_ALARM with fld=0; short -> DIS_H; four -> SEE_ALARM.
- DIS_H: same transitions as IDLE, except short -> IDLE.
- SET_TIME / SET_ALARM:
  - long with fld<NUM_FIELDS-1 -> fld+1.
  - long with fld=NUM_FIELDS-1 -> IDLE with fld=0.
  - triple -> IDLE, abort.
  - SET_ALARM only: short -> alarm_sel+1, wrapping NUM_ALARMS-1 -> 0; fld is unchanged.
- SEE_ALARM / SEE_ALARM_H: four -> IDLE; short toggles between the two states; double -> alarm_sel+1 with wrap.
- Output decode:
  - set_time = (1<<fld) in SET_TIME; set_alarm = (1<<fld) in SET_ALARM.
  - dis_toa = 1 in SET_ALARM, SEE_ALARM and SEE_ALARM_H.
  - dis_moh = 1 in DIS_H and SEE_ALARM_H, and in SET_* when fld=NUM_FIELDS-1.
- alarm_sel persists through IDLE; only reset clears it.
- Timeout:
  - tmo_cnt clears on any input pulse and on every IDLE cycle; otherwise it increments on tick_1hz.
  - If tmo_cnt=TIMEOUT_TICKS-1 and tick_1hz arrives with no event in that cycle: state -> IDLE, fld=0, timeout_pulse=1 for the next cycle.
  - An event coincident with the expiring tick wins and the timeout is cancelled.
- Reset mid-edit returns to IDLE the next edge. Field values held in other blocks are untouched.
- Illegal state encoding -> IDLE next cycle.

Decomposition:
- Shared package (set_pkg) holds:
  - the state enum (IDLE, DIS_H, SET_TIME, SET_ALARM, SEE_ALARM, SEE_ALARM_H);
  - the field index constants (FLD_SEC=0, FLD_MIN=1, FLD_HOUR);
  - an event-priority encode function.
- One natural sub-module, set_timeout_cnt: the tick counter with clear input and expiry pulse, parametrised by TIMEOUT_TICKS.

Test Plan:
- Reset, then pulse long x3, 10 cycles apart -> set_time 001, 010, 100 (dis_moh=1 on 100), then IDLE with all outputs 0.
- double, then short x5 (NUM_ALARMS=4) -> alarm_sel 1,2,3,0,1; set_alarm=001; dis_toa=1. Then triple -> IDLE with alarm_sel held at 1.
- long and triple in the same cycle from SET_TIME with fld=1 -> fld=2 (long wins), no abort.
- SET_ALARM with 29 ticks, short, then 29 ticks -> state held. The 30th tick after that -> IDLE, one-cycle timeout_pulse, set_alarm=000.
- four -> dis_toa=1, dis_moh=0; short -> dis_moh=1; double -> alarm_sel increments; four -> IDLE.
- Reset asserted while in SET_TIME with fld=2 and alarm_sel=3 -> next cycle all outputs 0 and alarm_sel=0.
